// File: rtl/alu_exec_unit.sv
// Purpose: handshaked ALU; add/sub/logic/slt in one cycle, shifts serial one bit per cycle.
// Latency: result valid 1 cycle after accept, or shamt+1 cycles for a shift with shamt != 0.
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             err
);

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SLT = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;
    localparam logic [3:0] FN_SRA = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] comb_res;
    logic             comb_err;
    logic             is_shift;
    logic [WIDTH-1:0] acc_shifted;
    logic             accept;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign o         = o_q;
    assign err       = err_q;
    assign accept    = in_valid && in_ready;
    assign is_shift  = (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);

    // Single-cycle result; shift codes only land here when shamt is zero, so they pass i2 through.
    always_comb begin
        comb_res = '0;
        comb_err = 1'b0;
        case (func)
            FN_ADD:  comb_res = i1 + i2;
            FN_SUB:  comb_res = i1 - i2;
            FN_AND:  comb_res = i1 & i2;
            FN_OR:   comb_res = i1 | i2;
            FN_XOR:  comb_res = i1 ^ i2;
            FN_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(i1) < $signed(i2))};
            FN_SLL,
            FN_SRL,
            FN_SRA:  comb_res = i2;
            default: begin
                comb_res = '0;
                comb_err = 1'b1;
            end
        endcase
    end

    // One-bit step of the serial shifter, selected by the captured op.
    always_comb begin
        acc_shifted = acc_q;
        case (op_q)
            FN_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            FN_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            FN_SRA:  acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: acc_shifted = acc_q;
        endcase
    end

    // Next-state and datapath control for IDLE/SHIFT/DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        o_d     = o_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = i2;
                        cnt_d   = shamt;
                        op_d    = func;
                        state_d = ST_SHIFT;
                    end else begin
                        o_d     = comb_res;
                        err_d   = comb_err;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    o_d     = acc_shifted;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset that also discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            o_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            o_q     <= o_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors for every op class,
// latency, backpressure hold, reset abort and illegal-op reporting.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [SHW-1:0]   shamt;
    logic [3:0]       func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             err;

    int n_checks = 0;
    int n_fails  = 0;

    alu_exec_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i1        (i1),
        .i2        (i2),
        .shamt     (shamt),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single accept edge, then waits (bounded) for out_valid.
    // lat counts edges from the accept edge up to and including the one raising out_valid.
    // in_ready must stay low on every cycle after accept until the result appears.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [SHW-1:0] sh, output int lat);
        logic ir_bad;
        ir_bad   = 1'b0;
        func     = f;
        i1       = a;
        i2       = b;
        shamt    = sh;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        i1       = ~a;
        i2       = ~b;
        lat      = 1;
        while (!out_valid && lat < 64) begin
            if (in_ready) ir_bad = 1'b1;
            tick();
            lat++;
        end
        check({tag, "_inrdy_low"}, 64'(ir_bad), 64'(0));
        check({tag, "_outvld"}, 64'(out_valid), 64'(1));
    endtask

    int lat;
    logic [WIDTH-1:0] held_o;
    logic             saw_vld;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i1        = '0;
        i2        = '0;
        shamt     = '0;
        func      = '0;
        tick();
        tick();
        check("rst_outvld", 64'(out_valid), 64'(0));
        check("rst_o",      64'(o),         64'(0));
        check("rst_err",    64'(err),       64'(0));
        check("rst_inrdy",  64'(in_ready),  64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_inrdy", 64'(in_ready), 64'(1));

        // Add, with out_ready high: DONE for exactly one cycle, then IDLE.
        run_op("add", 4'd0, 32'd45, 32'd61, 5'd0, lat);
        check("add_o",   64'(o),   64'(106));
        check("add_err", 64'(err), 64'(0));
        check("add_lat", 64'(lat), 64'(1));
        check("add_inrdy_in_done", 64'(in_ready), 64'(0));
        tick();
        check("add_back_idle_vld", 64'(out_valid), 64'(0));
        check("add_back_idle_rdy", 64'(in_ready),  64'(1));

        run_op("sub", 4'd1, 32'd45, 32'd61, 5'd0, lat);
        check("sub_o", 64'(o), 64'hFFFF_FFF0);
        check("sub_lat", 64'(lat), 64'(1));
        tick();

        run_op("slt_neg", 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd0, lat);
        check("slt_neg_o", 64'(o), 64'(1));
        tick();
        run_op("slt_pos", 4'd5, 32'd1, 32'hFFFF_FFFF, 5'd0, lat);
        check("slt_pos_o", 64'(o), 64'(0));
        tick();

        run_op("and", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, lat);
        check("and_o", 64'(o), 64'h00F0_00F0);
        tick();
        run_op("or", 4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, lat);
        check("or_o", 64'(o), 64'hFFF0_FFF0);
        tick();

        // Serial shifts by 3: four edges from accept to out_valid.
        run_op("srl", 4'd7, 32'h1234_5678, 32'hA034_1BB4, 5'd3, lat);
        check("srl_o",   64'(o),   64'h1406_8376);
        check("srl_lat", 64'(lat), 64'(4));
        check("srl_err", 64'(err), 64'(0));
        tick();
        run_op("sra", 4'd8, 32'h0, 32'hA034_1BB4, 5'd3, lat);
        check("sra_o",   64'(o),   64'hF406_8376);
        check("sra_lat", 64'(lat), 64'(4));
        tick();
        run_op("sll", 4'd6, 32'h0, 32'hA034_1BB4, 5'd3, lat);
        check("sll_o",   64'(o),   64'h01A0_DDA0);
        check("sll_lat", 64'(lat), 64'(4));
        tick();
        run_op("sll0", 4'd6, 32'h0, 32'hA034_1BB4, 5'd0, lat);
        check("sll0_o",   64'(o),   64'hA034_1BB4);
        check("sll0_lat", 64'(lat), 64'(1));
        tick();

        // Backpressure: result must hold while inputs churn and in_valid toggles.
        out_ready = 1'b0;
        run_op("bp", 4'd4, 32'hFFFF_0000, 32'h00FF_FF00, 5'd0, lat);
        check("bp_xor_o", 64'(o), 64'hFF00_FF00);
        held_o = o;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            func     = 4'(k + 1);
            i1       = 32'(k * 7 + 3);
            i2       = 32'(k * 13 + 1);
            tick();
            check($sformatf("bp_o_%0d", k),     64'(o),         64'(held_o));
            check($sformatf("bp_err_%0d", k),   64'(err),       64'(0));
            check($sformatf("bp_vld_%0d", k),   64'(out_valid), 64'(1));
            check($sformatf("bp_inrdy_%0d", k), 64'(in_ready),  64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_vld", 64'(out_valid), 64'(0));
        check("bp_release_rdy", 64'(in_ready),  64'(1));
        tick();
        check("bp_no_ghost_op", 64'(out_valid), 64'(0));

        // Reset on the 10th SHIFT cycle of a 31-bit sra aborts with no result.
        func     = 4'd8;
        i2       = 32'h8000_0001;
        shamt    = 5'd31;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        saw_vld  = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (out_valid) saw_vld = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        check("midrst_inrdy", 64'(in_ready), 64'(0));
        tick();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (out_valid) saw_vld = 1'b1;
            tick();
        end
        check("midrst_no_vld", 64'(saw_vld), 64'(0));
        check("midrst_o",      64'(o),       64'(0));
        check("midrst_inrdy_after", 64'(in_ready), 64'(1));
        run_op("add23", 4'd0, 32'd2, 32'd3, 5'd0, lat);
        check("add23_o",   64'(o),   64'(5));
        check("add23_lat", 64'(lat), 64'(1));
        tick();

        // Illegal op reports err and zero; next legal op clears err.
        run_op("ill", 4'd12, 32'h1234, 32'h5678, 5'd2, lat);
        check("ill_o",   64'(o),   64'(0));
        check("ill_err", 64'(err), 64'(1));
        check("ill_lat", 64'(lat), 64'(1));
        tick();
        run_op("after_ill", 4'd0, 32'd10, 32'd20, 5'd0, lat);
        check("after_ill_o",   64'(o),   64'(30));
        check("after_ill_err", 64'(err), 64'(0));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
